// File: rtl/spi_ctrl_pkg.sv
// Shared types and defaults for the SPI leader controller.
// States, default widths, and a counter-width helper.
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH,
    GAP
  } spi_state_e;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_SS_GAP     = 2;

  // Counter width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Divided serial clock: sck toggles every CLK_DIV enabled cycles.
// Ports: clk, rst_n, en in; sck level, rise/fall strobes (edge-ending cycle) out.
module spi_sck_gen
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int CW = cw(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          tc;

  // Strobes flag the cycle whose closing edge toggles sck.
  assign tc   = en && (cnt == CW'(CLK_DIV - 1));
  assign rise = tc && !sck;
  assign fall = tc && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tc) begin
      cnt <= '0;
      sck <= !sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_leader_arbiter.sv
// Shared SPI leader: arbitrates requesters, shifts winner's word MSB first
// (mode 0), adds one flush sck period, then holds ss high for SS_GAP cycles.
// Ports: clk, rst_n, req, tx_data in; grant, done, busy, sck, ss, mosi out.
// SPI_ARB_ROUND_ROBIN_EN: round-robin arbitration (default fixed, index 0 first).
module spi_leader_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int SS_GAP     = DEF_SS_GAP
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] tx_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          busy,
  output logic                          sck,
  output logic                          ss,
  output logic                          mosi
);

  localparam int IW = cw(NUM_REQ);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int GW = cw(SS_GAP);

  spi_state_e            state;
  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] sh_nx;
  logic [DATA_WIDTH-1:0] sel;
  logic [BW-1:0]         bit_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [IW-1:0]         win;
  logic [NUM_REQ-1:0]    hot;
  logic                  hit;
  logic                  sck_en;
  logic                  sck_rise;
  logic                  sck_fall;

`ifdef SPI_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr;
`endif

  assign sck_en = (state == SHIFT) || (state == FLUSH);
  assign sh_nx  = sh << 1;

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (sck_en),
    .sck  (sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  // Search order starts at 0 (fixed) or at ptr (round-robin).
  always_comb begin : arb
    int j;
    hit = 1'b0;
    win = '0;
    j   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = i;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      j = i + int'(ptr);
      if (j >= NUM_REQ) j = j - NUM_REQ;
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
        if (k == j && req[k] && !hit) begin
          hit = 1'b1;
          win = IW'(k);
        end
      end
    end
  end

  always_comb begin
    hot = '0;
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == win) begin
        hot[i] = 1'b1;
        sel    = tx_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ss      <= 1'b1;
      mosi    <= 1'b0;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      sh      <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      ptr     <= '0;
`endif
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (hit) begin
            state   <= SHIFT;
            ss      <= 1'b0;
            busy    <= 1'b1;
            grant   <= hot;
            sh      <= sel;
            mosi    <= sel[DATA_WIDTH-1];
            bit_cnt <= '0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
            ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
`endif
          end
        end
        SHIFT: begin
          if (sck_rise) bit_cnt <= bit_cnt + 1'b1;
          if (sck_fall) begin
            // All bits clocked: the flush period drives zero.
            if (bit_cnt == BW'(DATA_WIDTH)) begin
              state <= FLUSH;
              mosi  <= 1'b0;
            end else begin
              sh   <= sh_nx;
              mosi <= sh_nx[DATA_WIDTH-1];
            end
          end
        end
        FLUSH: begin
          if (sck_fall) begin
            state   <= GAP;
            ss      <= 1'b1;
            grant   <= '0;
            done    <= grant;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(SS_GAP - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_leader_arbiter.sv
// Bench for spi_leader_arbiter: scoreboard of expected words vs a follower model.
// Second instance covers CLK_DIV=1, DATA_WIDTH=16.
module tb_spi_leader_arbiter;

  localparam int SS_GAP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_a = '0;
  logic [15:0] tx_a = '0;
  logic [1:0]  grant_a, done_a;
  logic        busy_a, sck_a, ss_a, mosi_a;

  logic [0:0]  req_b = '0;
  logic [15:0] tx_b = '0;
  logic [0:0]  grant_b, done_b;
  logic        busy_b, sck_b, ss_b, mosi_b;

  spi_leader_arbiter #(
    .NUM_REQ(2), .DATA_WIDTH(8), .CLK_DIV(4), .SS_GAP(SS_GAP)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .tx_data(tx_a),
    .grant(grant_a), .done(done_a), .busy(busy_a),
    .sck(sck_a), .ss(ss_a), .mosi(mosi_a)
  );

  spi_leader_arbiter #(
    .NUM_REQ(1), .DATA_WIDTH(16), .CLK_DIV(1), .SS_GAP(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .tx_data(tx_b),
    .grant(grant_b), .done(done_b), .busy(busy_b),
    .sck(sck_b), .ss(ss_b), .mosi(mosi_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   mptr = 0;

  task automatic push(input int idx, input logic [7:0] d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    sb.push_back(e);
  endtask

  // Reference arbiter: lowest index, or rotating pointer when enabled.
  function automatic int arb(input logic [1:0] r);
    int w = -1;
    for (int i = 0; i < 2; i++) begin
      int j;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      j = (mptr + i) % 2;
`else
      j = i;
`endif
      if (w < 0 && ((r >> j) & 2'b01) != 0) w = j;
    end
`ifdef SPI_ARB_ROUND_ROBIN_EN
    mptr = (w + 1) % 2;
`endif
    return w;
  endfunction

  // Follower model for instance A.
  logic        pa_ss = 1'b1, pa_sck = 1'b0, pa_mosi = 1'b0;
  int          low_cnt = 0, hi_cnt = 0, gap_len = 0, nrise = 0;
  logic [31:0] rx = '0;

  always @(negedge clk) begin
    if (!ss_a) begin
      if (pa_ss) begin
        low_cnt = 0;
        nrise   = 0;
        rx      = '0;
        gap_len = hi_cnt;
        if (sb.size() > 0) begin
          chk("grant_at_ss", grant_a, 32'(1) << sb[0].idx);
          chk("mosi_msb", mosi_a, sb[0].data[7]);
        end
        chk("busy_at_ss", busy_a, 1);
      end
      low_cnt++;
      if (sck_a && !pa_sck) begin
        rx = {rx[30:0], mosi_a};
        nrise++;
        if (nrise == 1) chk("first_rise", low_cnt, 5);
      end
      if (sck_a && pa_sck) chk("mosi_hold", mosi_a, pa_mosi);
    end else begin
      if (!pa_ss) hi_cnt = 0;
      hi_cnt++;
    end
    if (done_a != 0) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", done_a, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_idx", done_a, 32'(1) << e.idx);
        chk("rx_word", (rx >> 1) & 32'hFF, e.data);
        chk("flush_bit", rx[0], 0);
        chk("nrise", nrise, 9);
        chk("ss_low", low_cnt, 72);
        chk("ss_at_done", ss_a, 1);
        chk("grant_clr", grant_a, 0);
        chk("busy_at_done", busy_a, 1);
      end
    end
    pa_ss   = ss_a;
    pa_sck  = sck_a;
    pa_mosi = mosi_a;
  end

  // Follower model for instance B (16-bit, sck period 2).
  logic [15:0] pat = 16'h8001;
  logic        pb_ss = 1'b1, pb_sck = 1'b0;
  int          nb = 0, lowb = 0, lastr = 0, cyc = 0, bdone = 0;

  always @(negedge clk) begin
    cyc++;
    if (!ss_b) begin
      if (pb_ss) begin
        nb   = 0;
        lowb = 0;
      end
      lowb++;
      if (sck_b && !pb_sck) begin
        if (nb > 0) chk("b_period", cyc - lastr, 2);
        chk("b_bit", mosi_b, (nb < 16) ? ((pat >> (15 - nb)) & 16'h1) : 0);
        lastr = cyc;
        nb++;
      end
    end
    if (done_b != 0) begin
      chk("b_rises", nb, 17);
      chk("b_ss_low", lowb, 34);
      bdone++;
    end
    pb_ss  = ss_b;
    pb_sck = sck_b;
  end

  task automatic wait_done(output logic [1:0] d);
    d = '0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done_a != 0) begin
        d = done_a;
        return;
      end
    end
    chk("timeout_done", 0, 1);
  endtask

  task automatic wait_ss_low();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!ss_a) return;
    end
    chk("timeout_ss", 0, 1);
  endtask

  initial begin
    logic [1:0] d;
    int w1, w2;

    repeat (3) @(negedge clk);
    chk("rst_sck", sck_a, 0);
    chk("rst_ss", ss_a, 1);
    chk("rst_mosi", mosi_a, 0);
    chk("rst_grant", grant_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_busy", busy_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request.
    tx_a[7:0] = 8'hA5;
    req_a = 2'b01;
    push(arb(2'b01), 8'hA5);
    wait_done(d);
    req_a = '0;
    repeat (3) @(negedge clk);
    chk("busy_idle", busy_a, 0);

    // Contention.
    tx_a = {8'hC3, 8'h3C};
    req_a = 2'b11;
    w1 = arb(2'b11);
    push(w1, w1 == 1 ? 8'hC3 : 8'h3C);
    w2 = arb(2'b11 & ~(2'b01 << w1));
    push(w2, w2 == 1 ? 8'hC3 : 8'h3C);
    wait_done(d);
    req_a = req_a & ~d;
    wait_done(d);
    req_a = '0;
    chk("gap_len", gap_len, SS_GAP + 1);
    repeat (5) @(negedge clk);

    // Both held for four transactions.
    req_a = 2'b11;
    for (int t = 0; t < 4; t++) begin
      w1 = arb(2'b11);
      push(w1, w1 == 1 ? 8'hC3 : 8'h3C);
    end
    for (int t = 0; t < 3; t++) wait_done(d);
    wait_done(d);
    req_a = '0;
    repeat (5) @(negedge clk);

    // Request dropped mid-shift.
    tx_a[7:0] = 8'hFF;
    req_a = 2'b01;
    push(arb(2'b01), 8'hFF);
    wait_ss_low();
    repeat (20) @(negedge clk);
    req_a = '0;
    wait_done(d);
    chk("drop_done", d, 2'b01);
    repeat (5) @(negedge clk);

    // Reset during the fifth sck high phase.
    tx_a[15:8] = 8'h5A;
    req_a = 2'b10;
    push(arb(2'b10), 8'h5A);
    wait_ss_low();
    for (int k = 0; k < 100 && nrise != 5; k++) @(negedge clk);
    chk("reached_rise5", nrise, 5);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ss", ss_a, 1);
    chk("abort_sck", sck_a, 0);
    chk("abort_grant", grant_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_mosi", mosi_a, 0);
    void'(sb.pop_front());
    mptr = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", done_a, 0);
    end
    push(arb(2'b10), 8'h5A);
    rst_n = 1'b1;
    wait_done(d);
    chk("post_rst_done", d, 2'b10);
    req_a = '0;
    repeat (5) @(negedge clk);

    // Wide word, fastest divider.
    tx_b = 16'h8001;
    req_b = 1'b1;
    for (int k = 0; k < 200 && done_b == 0; k++) @(negedge clk);
    req_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_done_cnt", bdone, 1);

    repeat (10) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
